// File: rtl/dac_sweep_sequencer.sv
// Pixel-to-DAC passthrough with a built-in calibration staircase generator.
// Owns the three DAC codes while sweeping 0..2**CODE_W-1 on the selected channels.
module dac_sweep_sequencer #(
    parameter int unsigned CODE_W  = 8,
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CODE_W-1:0]  pix_r,
    input  logic [CODE_W-1:0]  pix_g,
    input  logic [CODE_W-1:0]  pix_b,
    output logic [CODE_W-1:0]  dac_r,
    output logic [CODE_W-1:0]  dac_g,
    output logic [CODE_W-1:0]  dac_b,
    output logic               busy,
    output logic               done,
    output logic [CODE_W-1:0]  code
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_STEP = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

    localparam logic [1:0] MODE_RGB = 2'b00;
    localparam logic [1:0] MODE_R   = 2'b01;
    localparam logic [1:0] MODE_G   = 2'b10;
    localparam logic [1:0] MODE_B   = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  dac_r_q, dac_r_d;
    logic [CODE_W-1:0]  dac_g_q, dac_g_d;
    logic [CODE_W-1:0]  dac_b_q, dac_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic sel_r_c, sel_g_c, sel_b_c;

    // Channel selection from the latched mode, never the live input.
    always_comb begin
        sel_r_c = (mode_q == MODE_RGB) || (mode_q == MODE_R);
        sel_g_c = (mode_q == MODE_RGB) || (mode_q == MODE_G);
        sel_b_c = (mode_q == MODE_RGB) || (mode_q == MODE_B);
    end

    // Next-state and next-output logic; outputs default to zero.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        code_d  = '0;
        dac_r_d = '0;
        dac_g_d = '0;
        dac_b_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        if (!ena) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dac_r_d = pix_r;
                    dac_g_d = pix_g;
                    dac_b_d = pix_b;
                    if (start) begin
                        mode_d  = mode;
                        dwell_d = dwell;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dac_r_d = '0;
                        dac_g_d = '0;
                        dac_b_d = '0;
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (abort) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        busy_d = 1'b1;
                        code_d = code_q;
                        if (cnt_q == dwell_q) begin
                            cnt_d = '0;
                            if (code_q == CODE_MAX) begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                code_d  = '0;
                                state_d = ST_FIN;
                            end else begin
                                code_d = code_q + CODE_W'(1);
                            end
                        end else begin
                            cnt_d = cnt_q + DWELL_W'(1);
                        end
                        if (busy_d) begin
                            dac_r_d = sel_r_c ? code_d : '0;
                            dac_g_d = sel_g_c ? code_d : '0;
                            dac_b_d = sel_b_c ? code_d : '0;
                        end
                    end
                end
                ST_FIN: begin
                    // Resume passthrough so the first IDLE cycle already shows live pixels.
                    dac_r_d = pix_r;
                    dac_g_d = pix_g;
                    dac_b_d = pix_b;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            dac_r_q <= '0;
            dac_g_q <= '0;
            dac_b_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            dac_r_q <= dac_r_d;
            dac_g_q <= dac_g_d;
            dac_b_q <= dac_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dac_r = dac_r_q;
    assign dac_g = dac_g_q;
    assign dac_b = dac_b_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign code  = code_q;

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Directed bench for dac_sweep_sequencer: an elapsed-time sweep model is
// compared every cycle, plus literal spot checks that pin the model.
module tb_dac_sweep_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, start, abort;
    logic [1:0] mode;
    logic [7:0] dwell, pix_r, pix_g, pix_b;
    logic [7:0] dac_r, dac_g, dac_b, code;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    // Model: phase 0=passthrough, 1=sweeping, 2=finish cycle
    int         m_ph, m_t, m_dw, m_md;
    logic [7:0] m_dr, m_dg, m_db, m_code;
    logic       m_busy, m_done;

    dac_sweep_sequencer #(.CODE_W(8), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .mode(mode), .dwell(dwell), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b),
        .busy(busy), .done(done), .code(code)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        int nt;
        int c;
        if (!rst_n) begin
            m_ph <= 0; m_t <= 0; m_dw <= 0; m_md <= 0;
            m_dr <= 0; m_dg <= 0; m_db <= 0; m_code <= 0;
            m_busy <= 0; m_done <= 0;
        end else if (!ena) begin
            m_ph <= 0;
            m_dr <= 0; m_dg <= 0; m_db <= 0; m_code <= 0;
            m_busy <= 0; m_done <= 0;
        end else begin
            m_done <= 0;
            m_code <= 0;
            case (m_ph)
                0: begin
                    if (start) begin
                        m_ph <= 1; m_t <= 0;
                        m_dw <= int'(dwell); m_md <= int'(mode);
                        m_busy <= 1;
                        m_dr <= 0; m_dg <= 0; m_db <= 0;
                    end else begin
                        m_busy <= 0;
                        m_dr <= pix_r; m_dg <= pix_g; m_db <= pix_b;
                    end
                end
                1: begin
                    if (abort) begin
                        m_ph <= 0; m_busy <= 0;
                        m_dr <= 0; m_dg <= 0; m_db <= 0;
                    end else begin
                        nt = m_t + 1;
                        if (nt == 256 * (m_dw + 1)) begin
                            m_ph <= 2; m_done <= 1; m_busy <= 0;
                            m_dr <= 0; m_dg <= 0; m_db <= 0;
                        end else begin
                            c = nt / (m_dw + 1);
                            m_t <= nt;
                            m_code <= 8'(c);
                            m_dr <= (m_md == 0 || m_md == 1) ? 8'(c) : 8'd0;
                            m_dg <= (m_md == 0 || m_md == 2) ? 8'(c) : 8'd0;
                            m_db <= (m_md == 0 || m_md == 3) ? 8'(c) : 8'd0;
                        end
                    end
                end
                default: begin
                    m_ph <= 0; m_busy <= 0;
                    m_dr <= pix_r; m_dg <= pix_g; m_db <= pix_b;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock and compare every output with the model.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("dac_r", 32'(dac_r), 32'(m_dr));
        chk("dac_g", 32'(dac_g), 32'(m_dg));
        chk("dac_b", 32'(dac_b), 32'(m_db));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("done",  32'(done),  32'(m_done));
        chk("code",  32'(code),  32'(m_code));
    endtask

    task automatic launch(input logic [1:0] md, input logic [7:0] dw);
        mode = md; dwell = dw; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("first_step_busy", 32'(busy), 32'd1);
        chk("first_step_code", 32'(code), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
        mode = 2'b00; dwell = 8'd0; pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dac_r", 32'(dac_r), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_code",  32'(code),  32'd0);
        rst_n = 1'b1;

        // 1 passthrough
        pix_r = 8'h12; pix_g = 8'h34; pix_b = 8'h56;
        cyc();
        chk("pass_r", 32'(dac_r), 32'h12);
        chk("pass_g", 32'(dac_g), 32'h34);
        chk("pass_b", 32'(dac_b), 32'h56);
        chk("pass_done", 32'(done), 32'd0);

        // 2 full sweep, all channels, dwell 0
        launch(2'b00, 8'd0);
        for (int i = 1; i < 256; i++) begin
            cyc();
            chk("sweep_code", 32'(code), 32'(i));
            chk("sweep_dac_b", 32'(dac_b), 32'(i));
        end
        cyc();
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_dac_g", 32'(dac_g), 32'd0);
        cyc();
        chk("post_fin_done", 32'(done), 32'd0);
        chk("post_fin_pass_g", 32'(dac_g), 32'h34);

        // 3 green only, dwell 3
        launch(2'b10, 8'd3);
        for (int k = 1; k < 1024; k++) begin
            cyc();
            chk("g_dwell_dac_g", 32'(dac_g), 32'(k / 4));
            chk("g_dwell_dac_r", 32'(dac_r), 32'd0);
        end
        cyc();
        chk("g_fin_done", 32'(done), 32'd1);
        cyc();

        // 4 abort at code 0x40
        pix_r = 8'hA5;
        launch(2'b01, 8'd0);
        repeat (64) cyc();
        chk("pre_abort_code", 32'(code), 32'h40);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_code", 32'(code), 32'd0);
        chk("abort_dac_r", 32'(dac_r), 32'd0);
        cyc();
        chk("abort_pass_r", 32'(dac_r), 32'hA5);
        repeat (4) cyc();

        // 5 start while busy with dwell change, then start held through FIN
        launch(2'b00, 8'd1);
        repeat (32) cyc();
        chk("mid_code", 32'(code), 32'h10);
        start = 1'b1; dwell = 8'd7; mode = 2'b01;
        cyc();
        start = 1'b0;
        chk("no_restart_code", 32'(code), 32'h10);
        cyc();
        chk("step_len_kept", 32'(code), 32'h11);
        chk("mode_kept_dac_b", 32'(dac_b), 32'h11);
        repeat (477) cyc();
        chk("last_code", 32'(code), 32'hFF);
        start = 1'b1;
        cyc();
        chk("held_fin_done", 32'(done), 32'd1);
        cyc();
        chk("held_idle_busy", 32'(busy), 32'd0);
        cyc();
        start = 1'b0;
        chk("retrigger_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();

        // 6 ena drop mid-sweep, then async reset mid-sweep
        launch(2'b00, 8'd0);
        repeat (128) cyc();
        chk("pre_ena_code", 32'(code), 32'h80);
        ena = 1'b0;
        cyc();
        chk("ena_busy", 32'(busy), 32'd0);
        chk("ena_dac_r", 32'(dac_r), 32'd0);
        chk("ena_done", 32'(done), 32'd0);
        ena = 1'b1;
        cyc();
        launch(2'b00, 8'd0);
        repeat (20) cyc();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_dac_g", 32'(dac_g), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_code",  32'(code),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
